sigma_serial: RTL and testbench

//  Bit-serial SHA-256 small-sigma stage: ROTR(R1) ^ ROTR(R2) ^ SHR(S) of a w-bit word.

---
 rtl/sigma_serial.sv | 87 ++++++++
 tb/tb_sigma_serial.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sigma_serial.sv
// Bit-serial SHA-256 small sigma: records one word MSB-first per bclk frame and plays
// ROTR(R1)^ROTR(R2)^SHR(S) of it in the next frame. Optional SIGMA_SERIAL_BYPASS_EN adds a delay-line mode.
module sigma_serial #(
    parameter int w_sum = 32,
    parameter int R1    = 7,
    parameter int R2    = 18,
    parameter int S     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bclk,
    input  logic [$clog2(w_sum)-1:0] counter,
    input  logic                     in,
`ifdef SIGMA_SERIAL_BYPASS_EN
    input  logic                     bypass,
`endif
    output logic                     out,
    output logic                     valid
);

    logic             bclk_prev;
    logic [w_sum-2:0] sh;
    logic [w_sum-1:0] word;
    logic [w_sum-1:0] sig_msb;   // sigma bit for each counter value (index 0 = MSB)
    logic [w_sum-1:0] word_msb;  // raw word bit for each counter value
    logic             rise;
    logic             fall;
    logic             play_bit;
    logic             last_bit;

    assign rise     = !bclk_prev && bclk;
    assign fall     = bclk_prev && !bclk;
    assign last_bit = (int'(counter) == w_sum - 1);

    // Every rotate/shift index is a constant, so each output bit is a fixed XOR of word bits.
    for (genvar c = 0; c < w_sum; c++) begin : g_bit
        localparam int j  = w_sum - 1 - c;
        localparam int i1 = (j + R1) % w_sum;
        localparam int i2 = (j + R2) % w_sum;
        if (j + S < w_sum) begin : g_shift
            assign sig_msb[c] = word[i1] ^ word[i2] ^ word[j+S];
        end else begin : g_noshift
            assign sig_msb[c] = word[i1] ^ word[i2];
        end
        assign word_msb[c] = word[j];
    end

    always_comb begin
        play_bit = 1'b0;
        if (int'(counter) < w_sum) begin
`ifdef SIGMA_SERIAL_BYPASS_EN
            play_bit = bypass ? word_msb[counter] : sig_msb[counter];
`else
            play_bit = sig_msb[counter];
`endif
        end
    end

`ifndef SIGMA_SERIAL_BYPASS_EN
    logic unused_word_msb;
    assign unused_word_msb = ^word_msb;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_prev <= 1'b0;
            sh        <= '0;
            word      <= '0;
            out       <= 1'b0;
            valid     <= 1'b0;
        end else begin
            bclk_prev <= bclk;
            if (rise) begin
                sh <= {sh[w_sum-3:0], in};
                if (last_bit) begin
                    word  <= {sh, in};
                    valid <= 1'b1;
                end
            end
            // Plays at counter==w_sum-1 fall precede the capturing rise, so the old word is read.
            if (fall) begin
                out <= play_bit;
            end
        end
    end

endmodule

// File: tb/tb_sigma_serial.sv
// Bench for sigma_serial: sigma0 and sigma1 instances on one bclk frame, checked every bit
// against a word-level rotate/shift model, plus literal word-level pins.
module tb_sigma_serial;

    logic        clk;
    logic        rst;
    logic        bclk;
    logic [4:0]  counter;
    logic        in;
    logic        bypass;
    logic        out0, valid0, out1, valid1;

    int          n_total;
    int          n_pass;
    logic [31:0] m_word;
    logic        m_valid;
    logic [31:0] got0, got1;

    sigma_serial #(.w_sum(32), .R1(7), .R2(18), .S(3)) dut0 (
        .clk(clk), .rst(rst), .bclk(bclk), .counter(counter), .in(in),
`ifdef SIGMA_SERIAL_BYPASS_EN
        .bypass(bypass),
`endif
        .out(out0), .valid(valid0)
    );

    sigma_serial #(.w_sum(32), .R1(17), .R2(19), .S(10)) dut1 (
        .clk(clk), .rst(rst), .bclk(bclk), .counter(counter), .in(in),
`ifdef SIGMA_SERIAL_BYPASS_EN
        .bypass(1'b0),
`endif
        .out(out1), .valid(valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    function automatic logic [31:0] sigma(input logic [31:0] x, input int r1, input int r2, input int s);
        return rotr(x, r1) ^ rotr(x, r2) ^ (x >> s);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    endtask

    // One frame: per counter value, bclk falls (play) then rises (record).
    task automatic send_frame(input logic [31:0] data, input int stop_at, input logic byp);
        logic [31:0] exp0, exp1;
        logic        byp_eff;
`ifdef SIGMA_SERIAL_BYPASS_EN
        byp_eff = byp;
`else
        byp_eff = 1'b0;
`endif
        exp0 = byp_eff ? m_word : sigma(m_word, 7, 18, 3);
        exp1 = sigma(m_word, 17, 19, 10);
        got0 = '0;
        got1 = '0;
        for (int c = 0; c < 32; c++) begin
            counter = 5'(c);
            in      = data[31-c];
            bypass  = byp;
            bclk    = 1'b0;
            @(negedge clk);
            got0[31-c] = out0;
            got1[31-c] = out1;
            chk($sformatf("out0_bit%0d", c), {31'b0, out0}, {31'b0, exp0[31-c]});
            chk($sformatf("out1_bit%0d", c), {31'b0, out1}, {31'b0, exp1[31-c]});
            if (c == stop_at) return;
            bclk = 1'b1;
            @(negedge clk);
        end
        m_word  = data;
        m_valid = 1'b1;
        chk("valid0_frame_end", {31'b0, valid0}, {31'b0, m_valid});
        chk("valid1_frame_end", {31'b0, valid1}, {31'b0, m_valid});
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        m_word  = '0;
        m_valid = 1'b0;
        rst     = 1'b1;
        bclk    = 1'b0;
        counter = '0;
        in      = 1'b0;
        bypass  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out0", {31'b0, out0}, 32'h0);
        chk("reset_valid0", {31'b0, valid0}, 32'h0);
        chk("reset_out1", {31'b0, out1}, 32'h0);
        chk("reset_valid1", {31'b0, valid1}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        send_frame(32'h0000_0001, 99, 1'b0);
        chk("first_frame_out0", got0, 32'h0);
        send_frame(32'h8000_0000, 99, 1'b0);
        chk("sigma0_of_1", got0, 32'h0200_4000);
        chk("sigma1_of_1", got1, 32'h0000_A000);
        send_frame(32'hFFFF_FFFF, 99, 1'b0);
        chk("sigma0_of_msb", got0, 32'h1100_2000);
        send_frame(32'h1234_5678, 99, 1'b0);
        chk("sigma0_of_ones", got0, 32'h1FFF_FFFF);

        // Reset partway through a frame that is also playing sigma(0x12345678).
        send_frame(32'h0F0F_0F0F, 12, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_out0", {31'b0, out0}, 32'h0);
        chk("midreset_valid0", {31'b0, valid0}, 32'h0);
        chk("midreset_out1", {31'b0, out1}, 32'h0);
        chk("midreset_valid1", {31'b0, valid1}, 32'h0);
        rst     = 1'b0;
        m_word  = '0;
        m_valid = 1'b0;
        @(negedge clk);

        send_frame(32'h0000_0001, 99, 1'b0);
        chk("post_reset_out0", got0, 32'h0);
        send_frame(32'hDEAD_BEEF, 99, 1'b0);
        chk("post_reset_sigma0", got0, 32'h0200_4000);
        send_frame(32'hCAFE_F00D, 99, 1'b1);
`ifdef SIGMA_SERIAL_BYPASS_EN
        chk("bypass_delay", got0, 32'hDEAD_BEEF);
`endif
        send_frame(32'h0000_0000, 99, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
